instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the CPU's immediate sign-extension path: packs register fields, funct3, opcode and a 32-bit signed immediate into a 32-bit I-type or B-type instruction word.
- Streams encoded words, with incrementing byte addresses, to the instruction-memory write port used by the testbench/program loader.
- Valid/ready input, one registered output stage, word counter with full detection.

Parameters:
- address_width, 32, width of instruction word, immediate and memory address.
- DEPTH, 256, maximum words emitted before the block reports full.
- BASE_ADDR, 0, byte address of the first emitted word.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- restart  in  1  synchronous; clears counter/address/error, drops any held output.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- ImmSrc  in  1  1 = I-type, 0 = B-type (same encoding as decoder select).
- imm  in  address_width  signed immediate (byte offset for B-type).
- rs1  in  5  source register 1.
- rd_rs2  in  5  rd (I-type) or rs2 (B-type).
- funct3  in  3  funct3 field.
- opcode  in  7  opcode field.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  sink accepts when out_valid && out_ready.
- out_instr  out  address_width  encoded instruction.
- out_addr  out  address_width  byte address of out_instr.
- full  out  1  DEPTH words emitted.
- err  out  1  sticky range error (feature dependent).

Behaviour:
- Encoding, I-type: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd_rs2, [6:0]=opcode.
- Encoding, B-type: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rd_rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[4:1], [7]=imm[11], [6:0]=opcode. imm[0] ignored.
- Round-trip requirement: decoding any in-range encoded word through the CPU immediate extender returns the original imm.
- Reset (rst_n low, async): out_valid=0, out_instr=0, out_addr=BASE_ADDR, word count=0, full=0, err=0, state LOAD.
- States:
  - LOAD: in_ready = !full && (!out_valid || out_ready). Accepting a request registers the encoded word; out_valid rises the next cycle (latency 1).
  - Simultaneous output handshake and new accept is allowed: throughput 1 word/cycle.
  - Output handshake: out_addr += 4 and count += 1 on the following edge, and out_valid drops unless a new word is loaded.
  - When count reaches DEPTH, go to FULL: full=1, in_ready=0, out_valid=0, out_addr holds BASE_ADDR+4*DEPTH.
  - FULL: ignores in_valid. Leaves only on restart or reset.
- out_instr/out_addr held stable while out_valid && !out_ready.
- restart (any state): next cycle count=0, out_addr=BASE_ADDR, out_valid=0, err=0, state LOAD. A request presented in the restart cycle is not accepted (in_ready=0 while restart=1).
- Reset mid-stream discards the held word; no partial output.
- Address arithmetic wraps modulo 2^address_width.

Optional Feature:
- Macro: INSTR_ENCODER_RANGE_CHECK_EN.
- Defined:
  - I-type imm must lie in [-2048, 2047].
  - B-type imm must lie in [-4096, 4094] and be even.
  - Violating requests are consumed (handshake completes) but no word is emitted and the count does not advance; err sets sticky until restart/reset.
- Undefined: no checks; imm bits outside the field are silently truncated and err is tied 0.

Test Plan:
- Reset then I-type ImmSrc=1, imm=5, rs1=0, rd_rs2=1, funct3=0, opcode=0x13, out_ready=1 -> next cycle out_valid=1, out_instr=0x00500093, out_addr=0x0.
- B-type ImmSrc=0, imm=-4, rs1=1, rd_rs2=0, funct3=1, opcode=0x63 as second word -> out_instr=0xFE009EE3, out_addr=0x4.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_instr/out_addr stable; release -> words in order, no loss or duplication.
- DEPTH=4, stream 6 requests -> 4 words at 0x0,0x4,0x8,0xC; full=1; in_ready=0; pulse restart -> full=0, next word at 0x0.
- With INSTR_ENCODER_RANGE_CHECK_EN: I-type imm=2048 -> err=1, no out_valid; B-type imm=3 -> no word; following valid word still at the next address.
- Assert rst_n low while out_valid=1 and out_ready=0 -> out_valid=0 immediately, out_addr=BASE_ADDR, err=0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs rs1/rd_rs2/funct3/opcode and a signed immediate into an
// I-type or B-type instruction word. The words are streamed to an
// instruction-memory write port at incrementing byte addresses.
// Optional macro INSTR_ENCODER_RANGE_CHECK_EN: out-of-range immediates are
// consumed without emitting a word, and they set the sticky err flag.
module instr_encoder #(
  parameter int                       address_width = 32,
  parameter int                       DEPTH         = 256,
  parameter logic [address_width-1:0] BASE_ADDR     = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     restart,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     ImmSrc,
  input  logic [address_width-1:0] imm,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rd_rs2,
  input  logic [2:0]               funct3,
  input  logic [6:0]               opcode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [address_width-1:0] out_instr,
  output logic [address_width-1:0] out_addr,
  output logic                     full,
  output logic                     err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;

  logic [0:0]               state_q, state_d;
  logic                     out_valid_q, out_valid_d;
  logic [address_width-1:0] out_instr_q, out_instr_d;
  logic [address_width-1:0] out_addr_q, out_addr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     err_q, err_d;

  logic [31:0]              enc_word;
  logic                     imm_ok;
  logic                     out_fire;
  logic                     in_fire;

  // Field packing; B-type drops imm[0] because branch offsets are halfword aligned.
  always_comb begin
    if (ImmSrc)
      enc_word = {imm[11:0], rs1, funct3, rd_rs2, opcode};
    else
      enc_word = {imm[12], imm[10:5], rd_rs2, rs1, funct3, imm[4:1], imm[11], opcode};
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  // In range means the bits above the field are pure sign extension.
  always_comb begin
    if (ImmSrc)
      imm_ok = (imm[address_width-1:11] == '0) || (imm[address_width-1:11] == '1);
    else
      imm_ok = ((imm[address_width-1:12] == '0) || (imm[address_width-1:12] == '1)) && !imm[0];
  end
`else
  // No checking: the upper immediate bits are truncated away.
  logic unused_imm;
  assign unused_imm = &{1'b0, imm[address_width-1:13]};
  assign imm_ok     = 1'b1;
`endif

  // Accept while there is room. When the word leaving now fills the last slot,
  // a new word is refused so that it is not dropped on the transition to FULL.
  always_comb begin
    in_ready = !restart && (state_q == S_LOAD) && (!out_valid_q || out_ready) &&
               !(out_valid_q && (count_q == CW'(DEPTH - 1)));
  end

  assign out_fire = out_valid_q && out_ready;
  assign in_fire  = in_valid && in_ready;

  // Next-state logic: output retirement, new load, full detection and restart.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    count_d     = count_q;
    err_d       = err_q;
    if (restart) begin
      state_d     = S_LOAD;
      out_valid_d = 1'b0;
      out_addr_d  = BASE_ADDR;
      count_d     = '0;
      err_d       = 1'b0;
    end else if (state_q == S_LOAD) begin
      if (out_fire) begin
        out_valid_d = 1'b0;
        out_addr_d  = out_addr_q + address_width'(4);
        count_d     = count_q + CW'(1);
        if (count_q == CW'(DEPTH - 1)) state_d = S_FULL;
      end
      if (in_fire) begin
        if (imm_ok) begin
          out_valid_d = 1'b1;
          out_instr_d = address_width'(enc_word);
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // State registers; an async reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= BASE_ADDR;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign full      = (state_q == S_FULL);
  assign err       = err_q;

endmodule
